// File: rtl/ascon_pkg.sv
// ASCON-128 shared definitions: IV and padding constants,
// permutation state type, decrypt FSM encoding, round constants.
package ascon_pkg;

    localparam logic [63:0] ASCON_IV  = 64'h80400C0600000000;
    localparam logic [63:0] ASCON_PAD = 64'h8000000000000000;

    // x0 is element 0 and holds the rate word
    typedef logic [4:0][63:0] state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT_AD,
        ST_PROC_AD,
        ST_WAIT_CT,
        ST_PROC_CT,
        ST_FINAL
    } fsm_e;

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'd15 - r, r};
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One ASCON permutation round, purely combinational:
// constant addition, bitsliced S-box layer, linear diffusion layer.
module ascon_round
    import ascon_pkg::*;
(
    input  state_t     s_i,
    input  logic [3:0] r_i,
    output state_t     s_o
);

    function automatic logic [63:0] ror(
        input logic [63:0] x,
        input int unsigned n
    );
        return (x >> n) | (x << (64 - n));
    endfunction

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    // Single round: add constant to x2, S-box across all 64 slices, diffuse
    always_comb begin
        x0 = s_i[0];
        x1 = s_i[1];
        x2 = s_i[2] ^ {56'd0, round_const(r_i)};
        x3 = s_i[3];
        x4 = s_i[4];

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;

        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;

        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;

        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        s_o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        s_o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        s_o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        s_o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        s_o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    end

endmodule

// File: rtl/ascon128_decrypt.sv
// ASCON-128 authenticated decryption: one padded AD block, N_BLOCKS
// ciphertext blocks, one round per cycle, tag recomputed and compared.
module ascon128_decrypt
    import ascon_pkg::*;
#(
    parameter int N_BLOCKS = 3
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [127:0] tag_i,
    input  logic         data_valid_i,
    input  logic [63:0]  data_i,
    output logic         ready_o,
    output logic [63:0]  plain_o,
    output logic         plain_valid_o,
    output logic [127:0] tag_o,
    output logic         auth_ok_o,
    output logic         end_o
);

    localparam int BW = $clog2(N_BLOCKS + 1);

    fsm_e          state_q, state_d;
    state_t        s_q, s_d, s_rnd;
    logic [3:0]    rnd_q, rnd_d;
    logic [BW-1:0] blk_q, blk_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  exp_q, exp_d;
    logic [127:0]  tag_q, tag_d;
    logic [63:0]   plain_q, plain_d;
    logic          pv_q, pv_d;
    logic          ok_q, ok_d;
    logic          end_q, end_d;

    logic          last_rnd;
    logic [127:0]  tag_calc;

    ascon_round u_round (
        .s_i (s_q),
        .r_i (rnd_q),
        .s_o (s_rnd)
    );

    assign last_rnd = (rnd_q == 4'd11);
    assign tag_calc = {s_rnd[3], s_rnd[4]} ^ key_q;
    assign ready_o  = (state_q == ST_WAIT_AD) || (state_q == ST_WAIT_CT);

    // Next-state logic: FSM, permutation state, counters and outputs
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        key_d   = key_q;
        exp_d   = exp_q;
        tag_d   = tag_q;
        plain_d = plain_q;
        ok_d    = ok_q;
        pv_d    = 1'b0;
        end_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    s_d[0]  = ASCON_IV;
                    s_d[1]  = key_i[127:64];
                    s_d[2]  = key_i[63:0];
                    s_d[3]  = nonce_i[127:64];
                    s_d[4]  = nonce_i[63:0];
                    key_d   = key_i;
                    exp_d   = tag_i;
                    ok_d    = 1'b0;
                    rnd_d   = 4'd0;
                    blk_d   = '0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                s_d   = s_rnd;
                rnd_d = rnd_q + 4'd1;
                if (last_rnd) begin
                    s_d[3]  = s_rnd[3] ^ key_q[127:64];
                    s_d[4]  = s_rnd[4] ^ key_q[63:0];
                    state_d = ST_WAIT_AD;
                end
            end
            ST_WAIT_AD: begin
                if (data_valid_i) begin
                    s_d[0]  = s_q[0] ^ data_i;
                    rnd_d   = 4'd6;
                    state_d = ST_PROC_AD;
                end
            end
            ST_PROC_AD: begin
                s_d   = s_rnd;
                rnd_d = rnd_q + 4'd1;
                if (last_rnd) begin
                    s_d[4][0] = ~s_rnd[4][0];
                    state_d   = ST_WAIT_CT;
                end
            end
            ST_WAIT_CT: begin
                if (data_valid_i) begin
                    plain_d = s_q[0] ^ data_i;
                    pv_d    = 1'b1;
                    blk_d   = blk_q + BW'(1);
                    if (blk_q == BW'(N_BLOCKS - 1)) begin
                        s_d[0]  = data_i ^ ASCON_PAD;
                        s_d[1]  = s_q[1] ^ key_q[127:64];
                        s_d[2]  = s_q[2] ^ key_q[63:0];
                        rnd_d   = 4'd0;
                        state_d = ST_FINAL;
                    end else begin
                        s_d[0]  = data_i;
                        rnd_d   = 4'd6;
                        state_d = ST_PROC_CT;
                    end
                end
            end
            ST_PROC_CT: begin
                s_d   = s_rnd;
                rnd_d = rnd_q + 4'd1;
                if (last_rnd) begin
                    state_d = ST_WAIT_CT;
                end
            end
            ST_FINAL: begin
                s_d   = s_rnd;
                rnd_d = rnd_q + 4'd1;
                if (last_rnd) begin
                    tag_d   = tag_calc;
                    ok_d    = (tag_calc == exp_q);
                    end_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, all cleared by the asynchronous reset
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            rnd_q   <= '0;
            blk_q   <= '0;
            key_q   <= '0;
            exp_q   <= '0;
            tag_q   <= '0;
            plain_q <= '0;
            pv_q    <= 1'b0;
            ok_q    <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            exp_q   <= exp_d;
            tag_q   <= tag_d;
            plain_q <= plain_d;
            pv_q    <= pv_d;
            ok_q    <= ok_d;
            end_q   <= end_d;
        end
    end

    assign plain_o       = plain_q;
    assign plain_valid_o = pv_q;
    assign tag_o         = tag_q;
    assign auth_ok_o     = ok_q;
    assign end_o         = end_q;

endmodule
